// File: rtl/mmio_bridge_pkg.sv
// rtl/mmio_bridge_pkg.sv - MMIO port byte addresses and keyboard status word layout
package mmio_bridge_pkg;

  localparam logic [31:0] TIMER_BYTE_ADDR = 32'h0000_4000;
  localparam logic [31:0] KBD_BYTE_ADDR   = 32'h0000_4010;

  localparam int KBD_CODE_LSB  = 0;
  localparam int KBD_CODE_MSB  = 7;
  localparam int KBD_VALID_BIT = 8;
  localparam int KBD_OVF_BIT   = 9;

  function automatic logic [31:0] kbd_word(input logic ovf, input logic valid,
                                           input logic [7:0] code);
    logic [31:0] w;
    w = '0;
    w[KBD_CODE_MSB:KBD_CODE_LSB] = code;
    w[KBD_VALID_BIT] = valid;
    w[KBD_OVF_BIT] = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mmio_bridge_sync_fifo.sv
// rtl/mmio_bridge_sync_fifo.sv - first-word fall-through FIFO with flush, active-low sync reset
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - timer/keyboard MMIO decode on the CPU dmem path, gating cache strobes
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter logic [29:0] TIMER_ADDR = TIMER_BYTE_ADDR[31:2],
  parameter logic [29:0] KBD_ADDR   = KBD_BYTE_ADDR[31:2],
  parameter int          TICK_DIV   = 75000,
  parameter int          FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_w_en,
  input  logic        mem_stall,
  input  logic [31:0] cache_rdata,
  input  logic [7:0]  kbd_code,
  input  logic        kbd_valid,
  output logic        dc_read_out,
  output logic        dc_write_out,
  output logic [31:0] cpu_rdata
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          hit_t, hit_k, mmio, commit;
  logic          wr_t, wr_k, rd_k, pop, drop, tick;
  logic [PW-1:0] presc;
  logic [31:0]   timer_ms;
  logic          ovf;
  logic [7:0]    fifo_dout;
  logic          fifo_empty, fifo_full;

  assign hit_t        = (cpu_addr == TIMER_ADDR);
  assign hit_k        = (cpu_addr == KBD_ADDR);
  assign mmio         = hit_t | hit_k;
  assign dc_read_out  = cpu_read & ~mmio;
  assign dc_write_out = cpu_write & ~mmio;

  // Side effects wait for the stall to drop so a stalled access acts exactly once.
  assign commit = ~mem_stall;
  assign wr_t   = cpu_write & hit_t & commit;
  assign wr_k   = cpu_write & hit_k & commit;
  assign rd_k   = cpu_read & hit_k & commit;
  assign pop    = rd_k & ~cpu_write & ~fifo_empty;
  assign drop   = kbd_valid & fifo_full & ~pop & ~wr_k;
  assign tick   = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc    <= '0;
      timer_ms <= '0;
    end else if (wr_t) begin
      presc <= '0;
      for (int i = 0; i < 4; i++) begin
        if (cpu_byte_w_en[i]) timer_ms[8*i +: 8] <= cpu_wdata[8*i +: 8];
      end
    end else if (tick) begin
      presc    <= '0;
      timer_ms <= timer_ms + 32'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Flush wins over a drop, and a drop wins over the read-to-clear.
  always_ff @(posedge clk) begin
    if (!rst)      ovf <= 1'b0;
    else if (wr_k) ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
    else if (rd_k) ovf <= 1'b0;
  end

  sync_fifo #(.DW(8), .AW(FIFO_AW)) u_kbd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (kbd_valid),
    .din   (kbd_code),
    .pop   (pop),
    .flush (wr_k),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    cpu_rdata = cache_rdata;
    if (hit_t)      cpu_rdata = timer_ms;
    else if (hit_k) cpu_rdata = kbd_word(ovf, ~fifo_empty, fifo_empty ? 8'h00 : fifo_dout);
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - self-checking bench for mmio_bridge with queue-based reference model
module tb_mmio_bridge;

  localparam int          TICK_DIV = 4;
  localparam logic [29:0] TA       = 30'h0000_1000;
  localparam logic [29:0] KA       = 30'h0000_1004;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_read, cpu_write, mem_stall, kbd_valid;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata, cache_rdata;
  logic [3:0]  cpu_byte_w_en;
  logic [7:0]  kbd_code;
  logic        dc_read_out, dc_write_out;
  logic [31:0] cpu_rdata;

  always #5 clk = ~clk;

  mmio_bridge #(.TICK_DIV(TICK_DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_byte_w_en (cpu_byte_w_en),
    .mem_stall     (mem_stall),
    .cache_rdata   (cache_rdata),
    .kbd_code      (kbd_code),
    .kbd_valid     (kbd_valid),
    .dc_read_out   (dc_read_out),
    .dc_write_out  (dc_write_out),
    .cpu_rdata     (cpu_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: timer = value loaded at last write + whole ticks elapsed since; FIFO is a queue.
  logic [31:0] m_load;
  int          m_cyc;
  logic [7:0]  m_q[$];
  logic        m_ovf;

  function automatic logic [31:0] m_timer();
    return m_load + 32'(m_cyc / TICK_DIV);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] nxt;
    bit          hit_t, hit_k, commit, rd_k, dropped;
    hit_t   = (cpu_addr == TA);
    hit_k   = (cpu_addr == KA);
    commit  = !mem_stall;
    rd_k    = cpu_read && hit_k && commit;
    dropped = 0;
    if (!rst) begin
      m_load = '0;
      m_cyc  = 0;
      m_q.delete();
      m_ovf  = 1'b0;
      return;
    end
    if (cpu_write && hit_t && commit) begin
      nxt = m_timer();
      for (int b = 0; b < 4; b++)
        if (cpu_byte_w_en[b]) nxt[8*b +: 8] = cpu_wdata[8*b +: 8];
      m_load = nxt;
      m_cyc  = 0;
    end else begin
      m_cyc++;
    end
    if (cpu_write && hit_k && commit) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (rd_k && m_q.size() > 0) void'(m_q.pop_front());
      if (kbd_valid) begin
        if (m_q.size() < 16) m_q.push_back(kbd_code);
        else dropped = 1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (rd_k) m_ovf = 1'b0;
    end
  endtask

  task automatic check_comb(input string tag);
    logic [31:0] exp;
    bit          mmio;
    mmio = (cpu_addr == TA) || (cpu_addr == KA);
    if (cpu_addr == TA)      exp = m_timer();
    else if (cpu_addr == KA) exp = (m_q.size() == 0) ? {22'd0, m_ovf, 9'd0}
                                                     : {22'd0, m_ovf, 1'b1, m_q[0]};
    else                     exp = cache_rdata;
    check({tag, "/rdata"}, cpu_rdata, exp);
    check({tag, "/dc_read"}, 32'(dc_read_out), 32'(cpu_read && !mmio));
    check({tag, "/dc_write"}, 32'(dc_write_out), 32'(cpu_write && !mmio));
  endtask

  task automatic step(input string tag);
    #1;
    check_comb(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    cpu_addr      = 30'h100;
    cpu_wdata     = '0;
    cpu_byte_w_en = '0;
    mem_stall     = 1'b0;
    cache_rdata   = $urandom();
    kbd_valid     = 1'b0;
    kbd_code      = '0;
  endtask

  task automatic push(input logic [7:0] code);
    idle();
    kbd_valid = 1'b1;
    kbd_code  = code;
    step("push");
    idle();
  endtask

  task automatic wr(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] be);
    idle();
    cpu_write     = 1'b1;
    cpu_addr      = addr;
    cpu_wdata     = data;
    cpu_byte_w_en = be;
    step("wr");
    idle();
  endtask

  task automatic expect_rd(input logic [29:0] addr, input logic [31:0] exp, input string name);
    idle();
    cpu_read = 1'b1;
    cpu_addr = addr;
    #1;
    check(name, cpu_rdata, exp);
    step(name);
    idle();
  endtask

  typedef struct {
    logic        rd, wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stall;
    logic [31:0] cache;
    logic        valid;
    logic [31:0] exp_rdata;
    logic        exp_dcr, exp_dcw;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] exp_q[$];

  initial begin
    // Applied with rst held low: state stays zero, outputs still decode combinationally.
    vecs[0]  = '{1'b1, 1'b0, TA,        32'h0,         4'h0, 1'b0, 32'h1234_5678, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, KA,        32'h0,         4'h0, 1'b0, 32'h1234_5678, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 30'h100,   32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 30'h100,   32'h5555_AAAA, 4'hF, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, TA,        32'hFFFF_FFFF, 4'hF, 1'b0, 32'h1111_2222, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, TA,        32'h0,         4'h0, 1'b0, 32'h3333_4444, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 30'h2000,  32'h0,         4'h3, 1'b0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, KA + 30'd1, 32'h0,        4'h0, 1'b0, 32'h0000_0042, 1'b0, 32'h0000_0042, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, TA - 30'd1, 32'h0,        4'h0, 1'b1, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, KA,        32'h0,         4'h0, 1'b0, 32'h7777_7777, 1'b1, 32'h0,         1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, KA,        32'h0,         4'h0, 1'b0, 32'h7777_7777, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, TA,        32'h1234_5678, 4'hF, 1'b1, 32'h9999_9999, 1'b0, 32'h0,         1'b0, 1'b0};

    rst = 1'b0;
    idle();
    @(posedge clk);
    model_edge();
    #1;

    foreach (vecs[i]) begin
      cpu_read      = vecs[i].rd;
      cpu_write     = vecs[i].wr;
      cpu_addr      = vecs[i].addr;
      cpu_wdata     = vecs[i].wdata;
      cpu_byte_w_en = vecs[i].be;
      mem_stall     = vecs[i].stall;
      cache_rdata   = vecs[i].cache;
      kbd_valid     = vecs[i].valid;
      kbd_code      = 8'h5C;
      #1;
      check($sformatf("vec%0d/rdata", i), cpu_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d/dc_read", i), 32'(dc_read_out), 32'(vecs[i].exp_dcr));
      check($sformatf("vec%0d/dc_write", i), 32'(dc_write_out), 32'(vecs[i].exp_dcw));
      @(posedge clk);
      model_edge();
      #1;
    end

    rst = 1'b1;
    idle();
    for (int i = 0; i < 40; i++) step("run40");
    expect_rd(TA, 32'd10, "timer_40clk");
    step("pre_tick");
    step("pre_tick");
    wr(TA, 32'h0000_0100, 4'b0001);
    expect_rd(TA, 32'd0, "timer_load_on_tick");
    for (int i = 0; i < 3; i++) step("post_load");
    expect_rd(TA, 32'd1, "timer_after_load");

    wr(TA, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 3; i++) step("pre_wrap");
    expect_rd(TA, 32'hFFFF_FFFF, "timer_max");
    expect_rd(TA, 32'h0, "timer_wrap");

    idle();
    cpu_read = 1'b1;
    cpu_addr = KA;
    mem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("kbd_read_gated", 32'(dc_read_out), 32'd0);
      step("kbd_gate");
    end
    idle();

    push(8'h1C);
    push(8'h32);
    expect_rd(KA, 32'h11C, "fifo_first");
    expect_rd(KA, 32'h132, "fifo_second");
    expect_rd(KA, 32'h000, "fifo_empty");

    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    push(8'hAA);
    expect_rd(KA, 32'h340, "ovf_set_head");
    expect_rd(KA, 32'h141, "ovf_cleared");
    push(8'h50);
    push(8'h51);
    idle();
    cpu_read  = 1'b1;
    cpu_addr  = KA;
    kbd_valid = 1'b1;
    kbd_code  = 8'h77;
    #1;
    check("full_push_pop", cpu_rdata, 32'h142);
    step("full_push_pop");
    idle();
    push(8'h88);
    for (int i = 3; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h77);
    for (int i = 0; i < 16; i++)
      expect_rd(KA, {22'd0, (i == 0), 1'b1, exp_q[i]}, $sformatf("drain%0d", i));
    expect_rd(KA, 32'h0, "drain_empty");

    push(8'h5A);
    push(8'h5B);
    idle();
    cpu_read  = 1'b1;
    cpu_addr  = KA;
    mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall%0d/rdata", i), cpu_rdata, 32'h15A);
      check($sformatf("stall%0d/dc_read", i), 32'(dc_read_out), 32'd0);
      step("stall");
    end
    expect_rd(KA, 32'h15A, "stall_release_pop");
    expect_rd(KA, 32'h15B, "stall_single_pop");
    expect_rd(KA, 32'h0, "stall_empty");

    push(8'h01);
    push(8'h02);
    push(8'h03);
    idle();
    cpu_write     = 1'b1;
    cpu_addr      = KA;
    cpu_byte_w_en = 4'b0010;
    kbd_valid     = 1'b1;
    kbd_code      = 8'h99;
    step("flush3");
    expect_rd(KA, 32'h0, "flush3_empty");
    for (int i = 0; i < 17; i++) push(8'(i));
    idle();
    cpu_write = 1'b1;
    cpu_addr  = KA;
    kbd_valid = 1'b1;
    kbd_code  = 8'h66;
    step("flush_ovf");
    expect_rd(KA, 32'h0, "flush_ovf_clear");

    push(8'h11);
    for (int i = 0; i < 9; i++) step("run");
    idle();
    rst           = 1'b0;
    cpu_write     = 1'b1;
    cpu_addr      = TA;
    cpu_wdata     = 32'h1234_5678;
    cpu_byte_w_en = 4'hF;
    kbd_valid     = 1'b1;
    kbd_code      = 8'h22;
    step("rst_mid_write");
    rst = 1'b1;
    expect_rd(TA, 32'h0, "rst_timer");
    expect_rd(KA, 32'h0, "rst_kbd");

    for (int n = 0; n < 4000; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       cpu_addr = KA;
      else if (sel < 6)  cpu_addr = TA;
      else if (sel == 6) cpu_addr = KA + 30'd1;
      else               cpu_addr = 30'($urandom_range(0, 32'h3000));
      cpu_read      = ($urandom_range(0, 99) < 45);
      cpu_write     = ($urandom_range(0, 99) < ((cpu_addr == KA) ? 4 : 15));
      cpu_wdata     = $urandom();
      cpu_byte_w_en = 4'($urandom());
      mem_stall     = ($urandom_range(0, 99) < 25);
      cache_rdata   = $urandom();
      kbd_valid     = ($urandom_range(0, 99) < 45);
      kbd_code      = 8'($urandom());
      rst           = ($urandom_range(0, 499) != 0);
      step("rand");
    end
    rst = 1'b1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
